// File: rtl/reg_file_pkg.sv
// ============================================================================
// Module   : reg_file_pkg
// Purpose  : Shared types, default widths and bus-slicing helper for the
//            parametrised register file.
// Revision : 1.0
// ============================================================================
`default_nettype none

package reg_file_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } rf_state_e;

    // Low bit of field idx inside a flattened bus of width-wide fields.
    function automatic int unsigned field_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_rd_port.sv
// ============================================================================
// Module   : reg_file_rd_port
// Purpose  : One registered read port: zero-register check, write bypass,
//            storage mux and output register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run_i,
    input  logic [ADDR_W-1:0]             rd_addr_i,
    input  logic                          reg_write_i,
    input  logic [ADDR_W-1:0]             wr_addr_i,
    input  logic [DATA_W-1:0]             write_data_i,
    input  logic [(2**ADDR_W)*DATA_W-1:0] mem_flat_i,
    output logic [DATA_W-1:0]             rd_data_o
);

    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    always_comb begin
        rd_data_d = mem_flat_i[rd_addr_i * DATA_W +: DATA_W];
        if ((ZERO_REG != 0) && (rd_addr_i == '0)) begin
            rd_data_d = '0;
        end else if ((BYPASS != 0) && reg_write_i && (wr_addr_i == rd_addr_i)) begin
            rd_data_d = write_data_i;
        end
    end

    // Output is forced to zero for the whole clear walk.
    always_ff @(posedge clk) begin
        if (rst || !run_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/param_reg_file.sv
// ============================================================================
// Module   : param_reg_file
// Purpose  : Parametrised multi-read-port register file with hardware clear
//            walk, optional hardwired-zero entry and optional write bypass.
// Revision : 1.0
// ============================================================================
`default_nettype none

module param_reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     reg_write_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [DATA_W-1:0]        write_data_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic                     ready_o
);

    localparam int          DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

    rf_state_e                state_q;
    logic [ADDR_W:0]          cnt_q;
    logic                     ready_q;
    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [DEPTH*DATA_W-1:0]  mem_flat_w;
    logic                     run_w;
    logic                     wr_en_w;

    assign run_w   = (state_q == S_RUN);
    // A write coinciding with a clear request is dropped.
    assign wr_en_w = run_w && reg_write_i && !clear_i &&
                     !((ZERO_REG != 0) && (wr_addr_i == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + (ADDR_W+1)'(1);
                    end
                end
                S_RUN: begin
                    if (clear_i) begin
                        state_q <= S_CLEAR;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_CLEAR;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_CLEAR) begin
                mem_q[cnt_q[ADDR_W-1:0]] <= '0;
            end else if (wr_en_w) begin
                mem_q[wr_addr_i] <= write_data_i;
            end
        end
    end

    generate
        for (genvar e = 0; e < DEPTH; e++) begin : g_flat
            assign mem_flat_w[field_lo(e, DATA_W) +: DATA_W] = mem_q[e];
        end

        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
            reg_file_rd_port #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .ZERO_REG (ZERO_REG),
                .BYPASS   (BYPASS)
            ) u_rd_port (
                .clk          (clk),
                .rst          (rst),
                .run_i        (run_w),
                .rd_addr_i    (rd_addr_i[field_lo(p, ADDR_W) +: ADDR_W]),
                .reg_write_i  (reg_write_i),
                .wr_addr_i    (wr_addr_i),
                .write_data_i (write_data_i),
                .mem_flat_i   (mem_flat_w),
                .rd_data_o    (rd_data_o[field_lo(p, DATA_W) +: DATA_W])
            );
        end
    endgenerate

    assign ready_o = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_param_reg_file.sv
// ============================================================================
// Module   : tb_param_reg_file
// Purpose  : Self-checking bench for two param_reg_file configurations
//            (32x32/2 ports/zero+bypass, and 8x16/4 ports/plain).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_param_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra [4];

    logic [63:0] a_rd;
    logic        a_ready;
    logic [63:0] b_rd;
    logic        b_ready;

    int n_vec  = 0;
    int n_fail = 0;

    // Model state: instance 0 = A, instance 1 = B.
    logic [31:0] m_mem   [2][32];
    logic [31:0] m_rd    [2][4];
    bit          m_ready [2];
    bit          m_clr   [2];
    int          m_walk  [2];
    bit          started = 1'b0;

    always #5 clk = ~clk;

    param_reg_file #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)
    ) dut_a (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear),
        .reg_write_i  (we),
        .wr_addr_i    (wa),
        .write_data_i (wd),
        .rd_addr_i    ({ra[1], ra[0]}),
        .rd_data_o    (a_rd),
        .ready_o      (a_ready)
    );

    param_reg_file #(
        .DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0), .BYPASS(0)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear),
        .reg_write_i  (we),
        .wr_addr_i    (wa[2:0]),
        .write_data_i (wd[15:0]),
        .rd_addr_i    ({ra[3][2:0], ra[2][2:0], ra[1][2:0], ra[0][2:0]}),
        .rd_data_o    (b_rd),
        .ready_o      (b_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: clear lasts depth edges, then storage is all zero.
    task automatic model_step(input int k, input int depth, input int np, input bit z,
                              input bit byp, input logic [31:0] dmask, input int amask);
        logic [31:0] d;
        int          wa_l;
        int          ra_l;
        d    = wd & dmask;
        wa_l = int'(wa) & amask;
        if (rst) begin
            m_clr[k]   = 1'b1;
            m_walk[k]  = 0;
            m_ready[k] = 1'b0;
            for (int p = 0; p < 4; p++) m_rd[k][p] = '0;
        end else if (m_clr[k]) begin
            m_walk[k]++;
            for (int p = 0; p < 4; p++) m_rd[k][p] = '0;
            if (m_walk[k] == depth) begin
                m_clr[k]   = 1'b0;
                m_ready[k] = 1'b1;
                for (int i = 0; i < 32; i++) m_mem[k][i] = '0;
            end
        end else begin
            for (int p = 0; p < np; p++) begin
                ra_l = int'(ra[p]) & amask;
                if (z && ra_l == 0)                  m_rd[k][p] = '0;
                else if (byp && we && wa_l == ra_l)  m_rd[k][p] = d;
                else                                 m_rd[k][p] = m_mem[k][ra_l];
            end
            if (clear) begin
                m_clr[k]   = 1'b1;
                m_walk[k]  = 0;
                m_ready[k] = 1'b0;
            end else if (we && !(z && wa_l == 0)) begin
                m_mem[k][wa_l] = d;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 32, 2, 1'b1, 1'b1, 32'hFFFF_FFFF, 31);
        model_step(1, 8,  4, 1'b0, 1'b0, 32'h0000_FFFF, 7);
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("A_ready", {31'b0, a_ready}, {31'b0, m_ready[0]});
            chk("B_ready", {31'b0, b_ready}, {31'b0, m_ready[1]});
            for (int p = 0; p < 2; p++)
                chk($sformatf("A_rd%0d", p), a_rd[p*32 +: 32], m_rd[0][p]);
            for (int p = 0; p < 4; p++)
                chk($sformatf("B_rd%0d", p), {16'h0, b_rd[p*16 +: 16]}, m_rd[1][p]);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ra(input int a0, input int a1, input int a2, input int a3);
        ra[0] = 5'(a0); ra[1] = 5'(a1); ra[2] = 5'(a2); ra[3] = 5'(a3);
    endtask

    // Edge number (counted from the next edge) at which each ready rises; bounded.
    task automatic wait_ready(output int ta, output int tb);
        ta = -1;
        tb = -1;
        for (int e = 1; e <= 64; e++) begin
            step();
            if (ta < 0 && a_ready) ta = e;
            if (tb < 0 && b_ready) tb = e;
        end
    endtask

    int ta, tb;

    initial begin
        rst = 1'b1; clear = 1'b0; we = 1'b0; wa = '0; wd = '0;
        set_ra(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            m_clr[i] = 1'b1; m_walk[i] = 0; m_ready[i] = 1'b0;
            for (int p = 0; p < 4; p++) m_rd[i][p] = '0;
            for (int e = 0; e < 32; e++) m_mem[i][e] = '0;
        end

        // Reset, then initial clear walk.
        repeat (3) step();
        chk("reset_ready", {31'b0, a_ready}, 32'h0);
        chk("reset_rd",    a_rd[31:0], 32'h0);
        rst = 1'b0;
        wait_ready(ta, tb);
        chk("A_walk_len", 32'(ta), 32'd32);
        chk("B_walk_len", 32'(tb), 32'd8);

        // Every address reads zero after the walk.
        for (int a = 0; a < 32; a++) begin
            set_ra(a, 31 - a, a, 7 - (a & 7));
            step();
        end

        // Write then read r3; same-edge read shows bypass behaviour.
        we = 1'b1; wa = 5'd3; wd = 32'h8C12_3456;
        set_ra(0, 3, 3, 0);
        step();
        chk("A_bypass_r3", a_rd[63:32], 32'h8C12_3456);
        chk("B_nobyp_r3",  {16'h0, b_rd[31:16]}, 32'h0);
        we = 1'b0;
        set_ra(3, 0, 0, 0);
        step();
        chk("A_read_r3", a_rd[31:0], 32'h8C12_3456);
        chk("B_read_r3", {16'h0, b_rd[15:0]}, 32'h0000_3456);

        // Zero register.
        we = 1'b1; wa = 5'd0; wd = 32'hAD65_4321;
        set_ra(0, 0, 0, 0);
        step();
        we = 1'b0;
        step();
        chk("A_r0_p0", a_rd[31:0],  32'h0);
        chk("A_r0_p1", a_rd[63:32], 32'h0);
        chk("B_r0",    {16'h0, b_rd[15:0]}, 32'h0000_4321);

        // Fill r1..r9, then distinct and identical multi-port reads.
        for (int i = 1; i <= 9; i++) begin
            we = 1'b1; wa = 5'(i); wd = 32'hA000_0000 | (32'(i) * 32'h0101);
            step();
        end
        we = 1'b0;
        set_ra(1, 2, 3, 4);
        step();
        chk("B_distinct_p3", {16'h0, b_rd[63:48]}, 32'h0000_0404);
        chk("A_distinct_p1", a_rd[63:32], 32'hA000_0202);
        set_ra(5, 5, 5, 5);
        step();
        for (int p = 0; p < 4; p++)
            chk($sformatf("B_same_p%0d", p), {16'h0, b_rd[p*16 +: 16]}, 32'h0000_0505);
        chk("A_same_p0", a_rd[31:0], 32'hA000_0505);

        // Soft clear together with a write to r5.
        clear = 1'b1; we = 1'b1; wa = 5'd5; wd = 32'hFFFF_FFFF;
        set_ra(2, 9, 2, 2);
        step();
        chk("clr_ready_low", {31'b0, a_ready}, 32'h0);
        chk("clr_rd_run",    a_rd[63:32], 32'hA000_0909);
        clear = 1'b0; we = 1'b0;
        wait_ready(ta, tb);
        chk("A_clr_len", 32'(ta), 32'd32);
        chk("B_clr_len", 32'(tb), 32'd8);
        set_ra(5, 9, 5, 1);
        step();
        chk("A_r5_cleared", a_rd[31:0], 32'h0);
        for (int a = 0; a < 32; a++) begin
            set_ra(a, (a + 7) & 31, a, (a + 3) & 7);
            step();
        end

        // Reset in the middle of a clear walk.
        we = 1'b1; wa = 5'd4; wd = 32'h1234_5678;
        step();
        we = 1'b0; clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready(ta, tb);
        chk("A_rst_walk_len", 32'(ta), 32'd32);
        chk("B_rst_walk_len", 32'(tb), 32'd8);
        set_ra(4, 4, 4, 4);
        step();
        chk("A_r4_after_rst", a_rd[31:0], 32'h0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
